// File: rtl/rad4_mul_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
//   state_t     : controller states IDLE / RUN / FIN
//   booth_op_t  : Booth digit operations ZERO, +1x, +2x, -1x, -2x
//   booth_decode: 3-bit digit window -> Booth operation
//   mul_latency : start-to-done latency in cycles for a given operand width
package rad4_mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        P1,
        P2,
        M1,
        M2
    } booth_op_t;

    function automatic booth_op_t booth_decode(input logic [2:0] digit);
        booth_op_t op;
        case (digit)
            3'b001, 3'b010: op = P1;
            3'b011:         op = P2;
            3'b100:         op = M2;
            3'b101, 3'b110: op = M1;
            default:        op = ZERO;
        endcase
        return op;
    endfunction

    function automatic int unsigned mul_latency(input int unsigned width);
        return width / 2 + 2;
    endfunction

endpackage

// File: rtl/booth_rad4_sel.sv
// Radix-4 Booth partial-product selector (combinational).
//   digit : {y[2i+1], y[2i], y[2i-1]} window of the extended multiplier
//   mcand : multiplicand, already extended to WIDTH+2 bits
//   pp    : selected multiple, bit-inverted when the digit is negative
//   neg   : 1 for negative digits; the +1 of the two's complement is added
//           by the caller through the carry-vector LSB
module booth_rad4_sel
    import rad4_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 256
) (
    input  logic [2:0]       digit,
    input  logic [WIDTH+1:0] mcand,
    output logic [WIDTH+1:0] pp,
    output logic             neg
);

    booth_op_t        op;
    logic [WIDTH+1:0] mag;

    always_comb begin
        op  = booth_decode(digit);
        mag = '0;
        neg = 1'b0;
        case (op)
            P1: mag = mcand;
            P2: mag = {mcand[WIDTH:0], 1'b0};
            M1: begin
                mag = mcand;
                neg = 1'b1;
            end
            M2: begin
                mag = {mcand[WIDTH:0], 1'b0};
                neg = 1'b1;
            end
            default: mag = '0;
        endcase
        pp = neg ? ~mag : mag;
    end

endmodule

// File: rtl/rad4_booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or
// unsigned per operation, one Booth digit per cycle with carry-save
// accumulation.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : request, accepted only while idle
//   signed_mode       : operands are two's complement (honoured if SIGNED_EN)
//   x, y              : multiplicand / multiplier, captured on accept
//   busy              : operation in flight, including the done cycle
//   done              : one-cycle pulse, product valid from this cycle
//   out_low, out_high : product halves, held until the next done
module rad4_booth_mul_seq
    import rad4_mul_pkg::*;
#(
    parameter int unsigned WIDTH     = 256,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_low,
    output logic [WIDTH-1:0] out_high
);

    localparam int unsigned EW     = WIDTH + 2;
    localparam int unsigned AW     = WIDTH + 4;
    localparam int unsigned HW     = WIDTH - 2;
    localparam int unsigned DIGITS = WIDTH / 2 + 1;
    localparam int unsigned CNT_W  = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    // The accumulator runs in an offset-binary domain: it holds R + 2^(W+1)
    // and every partial product carries +3*2^(W+1). Sum and carry then stay
    // non-negative and below 2^AW, so both vectors can be shifted right
    // logically without any carry-save sign correction.
    localparam logic [AW-1:0] ACC_BIAS = {3'b001, {(WIDTH + 1){1'b0}}};

    state_t           state;
    logic [EW-1:0]    mcand;
    logic [EW-1:0]    mplier;
    logic             mprev;
    logic [AW-1:0]    sum_r;
    logic [AW-1:0]    carry_r;
    logic             cy_r;
    logic [EW-1:0]    low_r;
    logic [CNT_W-1:0] cnt;

    logic             mode_eff;
    logic [EW-1:0]    x_ext;
    logic [EW-1:0]    y_ext;

    logic [EW-1:0]    pp_sel;
    logic             neg;
    logic [AW-1:0]    pp_full;
    logic [AW-1:0]    csa_s;
    logic [AW-1:0]    csa_c;
    logic [2:0]       low_sum;
    logic [AW-1:0]    sum_nx;
    logic [AW-1:0]    carry_nx;
    logic             cy_nx;
    logic [EW-1:0]    low_nx;
    logic [HW-1:0]    hi_sum;
    logic [2*WIDTH-1:0] product;

    assign mode_eff = SIGNED_EN && signed_mode;
    assign x_ext    = {{2{mode_eff & x[WIDTH-1]}}, x};
    assign y_ext    = {{2{mode_eff & y[WIDTH-1]}}, y};

    booth_rad4_sel #(
        .WIDTH(WIDTH)
    ) u_sel (
        .digit(({mplier[1:0], mprev})),
        .mcand(mcand),
        .pp   (pp_sel),
        .neg  (neg)
    );

    // Flipping the selector's top bit adds 2^(W+1); the fixed 1 at bit W+2
    // adds the remaining 2^(W+2) of the per-digit offset.
    assign pp_full = {2'b01, ~pp_sel[EW-1], pp_sel[EW-2:0]};

    assign csa_s = sum_r ^ carry_r ^ pp_full;
    assign csa_c = {(sum_r[AW-2:0] & carry_r[AW-2:0]) |
                    (sum_r[AW-2:0] & pp_full[AW-2:0]) |
                    (carry_r[AW-2:0] & pp_full[AW-2:0]), neg};

    assign low_sum  = 3'(csa_s[1:0]) + 3'(csa_c[1:0]) + 3'(cy_r);
    assign sum_nx   = {2'b00, csa_s[AW-1:2]};
    assign carry_nx = {2'b00, csa_c[AW-1:2]};
    assign cy_nx    = low_sum[2];
    assign low_nx   = {low_sum[1:0], low_r[EW-1:2]};

    // Final resolve is taken straight off the last digit's CSA output so
    // the product is registered on the same edge that retires that digit.
    // The offset 2^(W+1) lies above the HW kept bits and drops out here.
    assign hi_sum  = sum_nx[HW-1:0] + carry_nx[HW-1:0] + HW'(cy_nx);
    assign product = {hi_sum, low_nx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            mprev    <= 1'b0;
            sum_r    <= '0;
            carry_r  <= '0;
            cy_r     <= 1'b0;
            low_r    <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out_low  <= '0;
            out_high <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand   <= x_ext;
                        mplier  <= y_ext;
                        mprev   <= 1'b0;
                        sum_r   <= ACC_BIAS;
                        carry_r <= '0;
                        cy_r    <= 1'b0;
                        low_r   <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_r   <= sum_nx;
                    carry_r <= carry_nx;
                    cy_r    <= cy_nx;
                    low_r   <= low_nx;
                    mplier  <= {2'b00, mplier[EW-1:2]};
                    mprev   <= mplier[1];
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        out_low  <= product[WIDTH-1:0];
                        out_high <= product[2*WIDTH-1:WIDTH];
                        done     <= 1'b1;
                        state    <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
